// File: rtl/trace_cmd_sequencer_pkg.sv
// Shared cache-specification constants and types for the trace command path.
package cache_specs;

  localparam int Command_size = 4;
  localparam int address_bits = 32;

  // Command code the statistics block treats as "no operation".
  localparam logic [Command_size-1:0] NOP_CMD = Command_size'(7);

  // One parsed trace line as buffered by the sequencer.
  typedef struct packed {
    logic                    last;
    logic [Command_size-1:0] cmd;
    logic [address_bits-1:0] addr;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    BUBBLE = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  // Codes the statistics block understands; everything else is dropped.
  function automatic logic is_legal_cmd(input logic [Command_size-1:0] c);
    return (c <= Command_size'(6)) || (c == Command_size'(8)) || (c == Command_size'(9));
  endfunction

endpackage

// File: rtl/trace_cmd_sequencer_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head data is read combinationally.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // A push is refused while full even if a pop happens in the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/trace_cmd_sequencer.sv
// Replays buffered trace entries to the statistics block, one command at a
// time, with a NOP bubble after each so repeated commands register as events.
// Handshake: an entry transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on registered state and rst, never on in_valid.
module trace_cmd_sequencer
  import cache_specs::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [Command_size-1:0] in_cmd,
  input  logic [address_bits-1:0] in_addr,
  input  logic                    in_last,
  output logic [Command_size-1:0] command,
  output logic [address_bits-1:0] address,
  output logic                    eof,
  output logic [31:0]             issued_count,
  output logic [15:0]             err_count,
  output seq_state_t              o_dbg_state
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  seq_state_t              r_state;
  logic [Command_size-1:0] r_cmd;
  logic [address_bits-1:0] r_addr;
  logic [HW-1:0]           r_hold;
  logic                    r_last;
  logic                    r_eof;
  logic                    r_sealed;
  logic [31:0]             r_issued;
  logic [15:0]             r_err;

  seq_state_t              w_state_nxt;
  logic [Command_size-1:0] w_cmd_nxt;
  logic [address_bits-1:0] w_addr_nxt;
  logic [HW-1:0]           w_hold_nxt;
  logic                    w_last_nxt;
  logic                    w_eof_nxt;
  logic                    w_issue_inc;
  logic                    w_err_inc;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_full;
  logic                    w_empty;
  trace_entry_t            w_head;

  assign in_ready     = !w_full && !r_sealed && !rst;
  assign w_push       = in_valid && in_ready;
  assign command      = r_cmd;
  assign address      = r_addr;
  assign eof          = r_eof;
  assign issued_count = r_issued;
  assign err_count    = r_err;
  assign o_dbg_state  = r_state;

  trace_fifo #(
    .WIDTH($bits(trace_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({in_last, in_cmd, in_addr}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state and next-output decode; outputs are registered so the
  // command seen downstream is glitch-free.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_addr_nxt  = r_addr;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_eof_nxt   = r_eof;
    w_issue_inc = 1'b0;
    w_err_inc   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_nxt = NOP_CMD;
        if (!w_empty) begin
          w_pop = 1'b1;
          if (is_legal_cmd(w_head.cmd)) begin
            w_cmd_nxt   = w_head.cmd;
            w_addr_nxt  = w_head.addr;
            w_hold_nxt  = '0;
            w_last_nxt  = w_head.last;
            w_issue_inc = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            // Dropped entry: outputs untouched, but a final illegal line still ends the trace.
            w_err_inc = 1'b1;
            if (w_head.last) begin
              w_state_nxt = DONE;
              w_eof_nxt   = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (r_hold == HW'(HOLD_CYCLES - 1)) begin
          w_cmd_nxt   = NOP_CMD;
          w_state_nxt = BUBBLE;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      BUBBLE: begin
        if (r_last) begin
          w_state_nxt = DONE;
          w_eof_nxt   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        w_cmd_nxt = NOP_CMD;
        w_eof_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, output and saturating counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cmd    <= NOP_CMD;
      r_addr   <= '0;
      r_hold   <= '0;
      r_last   <= 1'b0;
      r_eof    <= 1'b0;
      r_sealed <= 1'b0;
      r_issued <= '0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cmd    <= w_cmd_nxt;
      r_addr   <= w_addr_nxt;
      r_hold   <= w_hold_nxt;
      r_last   <= w_last_nxt;
      r_eof    <= w_eof_nxt;
      r_sealed <= r_sealed | (w_push && in_last);
      if (w_issue_inc && (r_issued != '1)) r_issued <= r_issued + 32'd1;
      if (w_err_inc && (r_err != '1))      r_err    <= r_err + 16'd1;
    end
  end

endmodule
